led_pattern_seq: RTL and testbench
==================================

Name: led_pattern_seq

Overview:
- Downstream consumer of the programmable tick counter.
- Takes the counter's single-cycle valid pulse as a step enable and drives an LED bank with a selectable pattern: shift-left, shift-right, flash or ping-pong.
- Advances exactly one pattern step per accepted tick and holds state otherwise.
- Sits between the tick counter and the board LED pins.

Parameters:
- NB_LEDS, 4, width of LED bank; legal range 2..16.
- NB_MODE, 2, width of mode select; fixed at 2.

Ports:
- clock  input  1  system clock; all state on rising edge.
- i_reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_valid  input  1  one-cycle step tick from upstream counter.
- i_mode  input  NB_MODE  pattern select: 00 SHIFT_L, 01 SHIFT_R, 10 FLASH, 11 PINGPONG.
- o_led  output  NB_LEDS  LED drive, 1 = lit.
- o_wrap  output  1  one-cycle pulse on pattern cycle boundary.
- o_mode  output  NB_MODE  currently active (latched) mode.

Behaviour:
- Reset (i_reset=0, async assert, sync release):
  - o_led = {0..01}; o_mode = 00; o_wrap = 0; direction reg = up; flash phase = on.
- No tick (i_valid=0): all state holds; o_wrap = 0.
- Mode sampling: i_mode is sampled only on cycles with i_valid=1. Changes between ticks are ignored.
- Mode change: tick with i_mode != o_mode. That tick performs no step. It latches o_mode and loads the seed:
  - SHIFT_L seed = LSB one-hot.
  - SHIFT_R seed = MSB one-hot.
  - FLASH seed = all ones, phase on.
  - PINGPONG seed = LSB one-hot, direction up.
  - o_wrap = 0 on that tick.
- Step: tick with i_mode == o_mode. o_led updates on the same clock edge, so new value is visible the cycle after i_valid.
- SHIFT_L: rotate left. MSB wraps to LSB; o_wrap=1 on the step that produces LSB one-hot.
- SHIFT_R: rotate right. LSB wraps to MSB; o_wrap=1 on the step that produces MSB one-hot.
- FLASH: toggles all ones <-> all zeros; o_wrap=1 on the step that produces all ones.
- PINGPONG:
  - Moves one position in current direction and reverses at the ends. End LEDs are shown once per pass, never twice.
  - Sequence for 4 LEDs: 0001,0010,0100,1000,0100,0010,0001,...
  - Direction flips on the step that lands on MSB or LSB.
  - o_wrap=1 on the step that lands on LSB.
- Robustness: if o_led is not a legal pattern for o_mode (zero or multi-hot in a shift mode), the next step loads that mode's seed and o_wrap=0.
- o_wrap is registered, high for exactly one cycle, and aligned with the o_led update.
- Reset mid-operation forces reset values immediately, regardless of clock.
- Internal FSM:
  - States: IDLE_HOLD (no tick), STEP, RELOAD (mode change or illegal pattern).
  - All transitions decided combinationally from i_valid, i_mode, o_mode and o_led; registered in one cycle.
  - No multi-cycle latency.

Optional Feature:
- Macro: LED_PRESCALE_EN.
- When defined:
  - Adds input i_prescale[1:0] and a 2-bit internal tick counter.
  - A step occurs only on every (i_prescale+1)-th tick; intermediate ticks only increment the counter.
  - The tick counter clears on reset, on mode-change reload, and after each step.
  - Mode-change detection still acts on the first tick that carries a new i_mode, regardless of prescale.
- When undefined: port absent; every tick is a step, exactly as above.

Test Plan:
- Reset then 4 ticks, mode 00, NB_LEDS=4 -> o_led 0001 at reset, then 0010,0100,1000,0001; o_wrap high only with the 0001 update.
- Mode 11, 8 ticks from reset -> first tick reloads seed 0001 with o_wrap=0; next 7 ticks give 0010,0100,1000,0100,0010,0001,0010; o_wrap high once, on the step to 0001.
- Mode 10, ticks spaced 5 cycles apart -> first tick loads 1111; following ticks give 0000,1111,0000; o_wrap on each step to 1111; o_led stable between ticks.
- Toggle i_mode 00->01->00 with no i_valid, then one tick -> o_mode stays 00 and o_led shifts left by one step.
- Pull i_reset low mid-SHIFT_R at o_led=0100, asynchronously between edges -> o_led=0001, o_mode=00, o_wrap=0 immediately; state holds until reset releases and the next tick arrives.
- LED_PRESCALE_EN defined, i_prescale=2, mode 00, 9 ticks -> o_led steps on ticks 3, 6 and 9 only (0010,0100,1000).

Source files
------------

// File: rtl/led_pattern_seq.sv
// led_pattern_seq
//   Drives an LED bank from the single-cycle valid pulse of an upstream tick
//   counter. Every accepted tick either advances the selected pattern by one
//   step or reloads the seed for a newly selected or corrupted pattern. With
//   no tick, all state holds.
//
//   Patterns (i_mode): 00 SHIFT_L, 01 SHIFT_R, 10 FLASH, 11 PINGPONG.
//
//   Ports:
//     clock      - system clock, all state on the rising edge
//     i_reset    - asynchronous active-low reset (async assert, sync release)
//     i_valid    - one-cycle step tick from the upstream counter
//     i_mode     - pattern select, sampled only on ticks
//     i_prescale - (LED_PRESCALE_EN only) step on every (i_prescale+1)-th tick
//     o_led      - LED drive, 1 = lit
//     o_wrap     - one-cycle pulse on a pattern cycle boundary
//     o_mode     - currently latched mode
//
//   Build option: define LED_PRESCALE_EN to add i_prescale and the internal
//   2-bit tick prescaler. Without it every accepted tick is a step.
module led_pattern_seq #(
  parameter int unsigned NB_LEDS = 4,
  parameter int unsigned NB_MODE = 2
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_MODE-1:0] i_mode,
`ifdef LED_PRESCALE_EN
  input  logic [1:0]         i_prescale,
`endif
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_wrap,
  output logic [NB_MODE-1:0] o_mode
);

  typedef enum logic [1:0] {
    SHIFT_L  = 2'b00,
    SHIFT_R  = 2'b01,
    FLASH    = 2'b10,
    PINGPONG = 2'b11
  } mode_t;

  // Action taken on the current cycle; the result lands in the output
  // registers on the same clock edge, so there is no multi-cycle latency.
  typedef enum logic [1:0] {
    IDLE_HOLD = 2'b00,
    STEP      = 2'b01,
    RELOAD    = 2'b10
  } state_t;

  localparam logic [NB_LEDS-1:0] LSB_HOT = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] MSB_HOT = {1'b1, {(NB_LEDS-1){1'b0}}};

  function automatic logic [NB_LEDS-1:0] seed_for(input mode_t m);
    case (m)
      SHIFT_R: seed_for = MSB_HOT;
      FLASH:   seed_for = '1;
      default: seed_for = LSB_HOT;
    endcase
  endfunction

  logic               dir_up;     // pingpong travel direction
  logic               flash_on;   // flash phase: 1 = all lit
`ifdef LED_PRESCALE_EN
  logic [1:0]         cnt;        // ticks accepted since the last step
`endif

  state_t             act;
  mode_t              cur_mode;
  mode_t              new_mode;
  logic               mode_chg;
  logic               legal;
  logic               step_due;
  logic               go_up;
  logic [NB_LEDS-1:0] step_led;
  logic               step_wrap;
  logic               step_dir;
  logic               step_phase;

  always_comb begin
    cur_mode   = mode_t'(o_mode);
    new_mode   = mode_t'(i_mode);
    mode_chg   = (i_mode != o_mode);

    // Shift-style modes need exactly one lit LED; flash needs all or none.
    case (cur_mode)
      FLASH:   legal = (&o_led) | ~(|o_led);
      default: legal = $onehot(o_led);
    endcase

`ifdef LED_PRESCALE_EN
    step_due = (cnt == i_prescale);
`else
    step_due = 1'b1;
`endif

    act = IDLE_HOLD;
    if (i_valid) begin
      if (mode_chg)
        act = RELOAD;
      else if (step_due)
        act = legal ? STEP : RELOAD;
    end

    step_led   = o_led;
    step_wrap  = 1'b0;
    step_dir   = dir_up;
    step_phase = flash_on;
    go_up      = 1'b0;
    case (cur_mode)
      SHIFT_L: begin
        step_led  = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
        step_wrap = (step_led == LSB_HOT);
      end
      SHIFT_R: begin
        step_led  = {o_led[0], o_led[NB_LEDS-1:1]};
        step_wrap = (step_led == MSB_HOT);
      end
      FLASH: begin
        step_led   = flash_on ? '0 : '1;
        step_phase = ~flash_on;
        step_wrap  = ~flash_on;
      end
      default: begin
        // An end LED is never shown twice: the direction flips on the step
        // that lands on an end. The position checks also keep travel inward
        // should the direction register ever disagree with the LED position.
        go_up = dir_up ? ~o_led[NB_LEDS-1] : o_led[0];
        if (go_up) begin
          step_led = o_led << 1;
          step_dir = ~step_led[NB_LEDS-1];
        end else begin
          step_led  = o_led >> 1;
          step_dir  = step_led[0];
          step_wrap = step_led[0];
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_led    <= LSB_HOT;
      o_mode   <= '0;
      o_wrap   <= 1'b0;
      dir_up   <= 1'b1;
      flash_on <= 1'b1;
`ifdef LED_PRESCALE_EN
      cnt      <= '0;
`endif
    end else begin
      o_wrap <= 1'b0;
      case (act)
        IDLE_HOLD: begin
`ifdef LED_PRESCALE_EN
          if (i_valid)
            cnt <= cnt + 2'd1;
`endif
        end
        STEP: begin
          o_led    <= step_led;
          o_wrap   <= step_wrap;
          dir_up   <= step_dir;
          flash_on <= step_phase;
`ifdef LED_PRESCALE_EN
          cnt      <= '0;
`endif
        end
        RELOAD: begin
          // On an illegal pattern i_mode equals o_mode, so the same path
          // reloads the current mode's seed.
          o_mode   <= i_mode;
          o_led    <= seed_for(new_mode);
          dir_up   <= 1'b1;
          flash_on <= 1'b1;
`ifdef LED_PRESCALE_EN
          cnt      <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Testbench for led_pattern_seq (NB_LEDS=4): directed ticks push expected
// outputs into a queue; a monitor pops one entry the cycle after each tick
// and otherwise checks that outputs hold.
module tb_led_pattern_seq;

  logic       clock;
  logic       i_reset;
  logic       i_valid;
  logic [1:0] i_mode;
`ifdef LED_PRESCALE_EN
  logic [1:0] i_prescale;
`endif
  logic [3:0] o_led;
  logic       o_wrap;
  logic [1:0] o_mode;

  typedef struct packed {
    logic [3:0] led;
    logic       wrap;
    logic [1:0] mode;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic tick_d;
  int   total = 0;
  int   bad   = 0;

  led_pattern_seq #(.NB_LEDS(4), .NB_MODE(2)) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .i_mode    (i_mode),
`ifdef LED_PRESCALE_EN
    .i_prescale(i_prescale),
`endif
    .o_led     (o_led),
    .o_wrap    (o_wrap),
    .o_mode    (o_mode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge i_reset) begin
    if (!i_reset) tick_d <= 1'b0;
    else          tick_d <= i_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_led"},  32'(o_led),  32'(e.led));
    chk({tag, "_wrap"}, 32'(o_wrap), 32'(e.wrap));
    chk({tag, "_mode"}, 32'(o_mode), 32'(e.mode));
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!i_reset) begin
      q.delete();
      cur = '{led: 4'b0001, wrap: 1'b0, mode: 2'b00};
      chk_out("reset", cur);
    end else if (tick_d) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: tick seen with no expected entry at %0t", $time);
      end else begin
        cur = q.pop_front();
        chk_out("tick", cur);
      end
    end else begin
      // Between ticks outputs hold and the wrap pulse has ended.
      chk_out("hold", '{led: cur.led, wrap: 1'b0, mode: cur.mode});
    end
  end

  // Entered at a falling edge; leaves at a falling edge.
  task automatic tick(input logic [1:0] mode, input logic [3:0] led,
                      input logic wrap, input logic [1:0] emode, input int unsigned gap);
    i_valid = 1'b1;
    i_mode  = mode;
    q.push_back('{led: led, wrap: wrap, mode: emode});
    @(negedge clock);
    i_valid = 1'b0;
    for (int unsigned g = 0; g < gap; g++) @(negedge clock);
  endtask

  // Reset asserted between edges and checked before any clock edge.
  task automatic do_reset();
    #2 i_reset = 1'b0;
    #1;
    chk_out("async_rst", '{led: 4'b0001, wrap: 1'b0, mode: 2'b00});
    #9 i_reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_mode  = 2'b00;
`ifdef LED_PRESCALE_EN
    i_prescale = 2'd0;
`endif
    repeat (3) @(negedge clock);
    #2 i_reset = 1'b1;
    @(negedge clock);
    @(negedge clock);

    // SHIFT_L from reset: wrap only on the step back to 0001.
    tick(2'b00, 4'b0010, 1'b0, 2'b00, 1);
    tick(2'b00, 4'b0100, 1'b0, 2'b00, 1);
    tick(2'b00, 4'b1000, 1'b0, 2'b00, 0);
    tick(2'b00, 4'b0001, 1'b1, 2'b00, 1);

    // i_mode wiggles without a tick are ignored.
    i_mode = 2'b01; repeat (2) @(negedge clock);
    i_mode = 2'b10; @(negedge clock);
    i_mode = 2'b00; @(negedge clock);
    tick(2'b00, 4'b0010, 1'b0, 2'b00, 1);

    do_reset();
    @(negedge clock);

    // PINGPONG, back-to-back ticks.
    tick(2'b11, 4'b0001, 1'b0, 2'b11, 0);
    tick(2'b11, 4'b0010, 1'b0, 2'b11, 0);
    tick(2'b11, 4'b0100, 1'b0, 2'b11, 0);
    tick(2'b11, 4'b1000, 1'b0, 2'b11, 0);
    tick(2'b11, 4'b0100, 1'b0, 2'b11, 0);
    tick(2'b11, 4'b0010, 1'b0, 2'b11, 0);
    tick(2'b11, 4'b0001, 1'b1, 2'b11, 0);
    tick(2'b11, 4'b0010, 1'b0, 2'b11, 1);
    tick(2'b11, 4'b0100, 1'b0, 2'b11, 1);
    tick(2'b11, 4'b1000, 1'b0, 2'b11, 1);
    tick(2'b00, 4'b0001, 1'b0, 2'b00, 1);
    tick(2'b11, 4'b0001, 1'b0, 2'b11, 1);
    tick(2'b11, 4'b0010, 1'b0, 2'b11, 1);

    // FLASH, ticks 5 cycles apart, then phase restored by a reload.
    tick(2'b10, 4'b1111, 1'b0, 2'b10, 5);
    tick(2'b10, 4'b0000, 1'b0, 2'b10, 5);
    tick(2'b10, 4'b1111, 1'b1, 2'b10, 5);
    tick(2'b10, 4'b0000, 1'b0, 2'b10, 5);
    tick(2'b00, 4'b0001, 1'b0, 2'b00, 1);
    tick(2'b10, 4'b1111, 1'b0, 2'b10, 1);
    tick(2'b10, 4'b0000, 1'b0, 2'b10, 1);

    // SHIFT_R full cycle, then async reset while showing 0100.
    tick(2'b01, 4'b1000, 1'b0, 2'b01, 1);
    tick(2'b01, 4'b0100, 1'b0, 2'b01, 1);
    tick(2'b01, 4'b0010, 1'b0, 2'b01, 1);
    tick(2'b01, 4'b0001, 1'b0, 2'b01, 1);
    tick(2'b01, 4'b1000, 1'b1, 2'b01, 1);
    tick(2'b01, 4'b0100, 1'b0, 2'b01, 0);
    i_mode = 2'b00;
    do_reset();
    repeat (3) @(negedge clock);
    tick(2'b00, 4'b0010, 1'b0, 2'b00, 1);

`ifdef LED_PRESCALE_EN
    // Step only on every third tick.
    do_reset();
    i_prescale = 2'd2;
    @(negedge clock);
    for (int unsigned t = 1; t <= 9; t++) begin
      case (t)
        1, 2:    tick(2'b00, 4'b0001, 1'b0, 2'b00, 1);
        3, 4, 5: tick(2'b00, 4'b0010, 1'b0, 2'b00, 1);
        6, 7, 8: tick(2'b00, 4'b0100, 1'b0, 2'b00, 1);
        default: tick(2'b00, 4'b1000, 1'b0, 2'b00, 1);
      endcase
    end
`endif

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
